// File: rtl/scan_sequencer_if.sv
// Bundle between scan_sequencer and its controller: control inputs plus the
// select / enable-code / frame outputs that feed the 3-to-8 decoder.
interface scan_sequencer_if;
    logic       en;
    logic       run;
    logic       step;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] sel;
    logic [1:0] ena;
    logic       frame;

    modport master (
        output en, run, step, dir, load, load_val,
        input  sel, ena, frame
    );

    modport slave (
        input  en, run, step, dir, load, load_val,
        output sel, ena, frame
    );
endinterface

// File: rtl/scan_sequencer.sv
// Scans a 3-bit decoder select through positions 0..7 (free-run or single-step),
// blanking the decoder enable after every advance and pulsing frame on wrap.
module scan_sequencer #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned BLANK = 1
) (
    input logic             clk,
    input logic             rst,
    scan_sequencer_if.slave bus
);
    localparam int unsigned    PW         = (DIV > 32'd1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 32'd1);
    localparam logic [7:0]     BLANK_INIT = (BLANK > 32'd0) ? 8'(BLANK - 32'd1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHOW  = 2'b01,
        ST_BLANK = 2'b10
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [7:0]    blank_r, blank_s;
    logic          step_prev_r;
    logic [2:0]    sel_r, sel_s;
    logic [1:0]    ena_r, ena_s;
    logic          frame_r, frame_s;
    logic          tick_s;
    logic          advance_s;

    assign tick_s = (presc_r == PRESC_LAST);

    // Next-state, position, prescaler, blank counter and frame decision.
    always_comb begin
        state_s   = state_r;
        presc_s   = presc_r;
        blank_s   = blank_r;
        sel_s     = sel_r;
        frame_s   = 1'b0;
        advance_s = 1'b0;
        if (!bus.en) begin
            state_s = ST_IDLE;
            presc_s = {PW{1'b0}};
            blank_s = 8'd0;
        end else if (bus.load) begin
            sel_s   = bus.load_val;
            presc_s = {PW{1'b0}};
            blank_s = 8'd0;
            state_s = ST_SHOW;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_SHOW;
                    presc_s = {PW{1'b0}};
                end
                ST_SHOW: begin
                    if (bus.run) begin
                        advance_s = tick_s;
                        if (tick_s) begin
                            presc_s = {PW{1'b0}};
                        end else begin
                            presc_s = presc_r + PW'(1'b1);
                        end
                    end else begin
                        // Step edges only count here; elsewhere they are simply dropped.
                        advance_s = bus.step & ~step_prev_r;
                        presc_s   = {PW{1'b0}};
                    end
                    if (advance_s) begin
                        if (bus.dir) begin
                            sel_s   = sel_r - 3'd1;
                            frame_s = (sel_r == 3'd0);
                        end else begin
                            sel_s   = sel_r + 3'd1;
                            frame_s = (sel_r == 3'd7);
                        end
                        if (BLANK > 32'd0) begin
                            state_s = ST_BLANK;
                            blank_s = BLANK_INIT;
                        end else begin
                            state_s = ST_SHOW;
                        end
                    end else begin
                        state_s = ST_SHOW;
                    end
                end
                ST_BLANK: begin
                    presc_s = {PW{1'b0}};
                    if (blank_r == 8'd0) begin
                        state_s = ST_SHOW;
                    end else begin
                        blank_s = blank_r - 8'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    presc_s = {PW{1'b0}};
                    blank_s = 8'd0;
                end
            endcase
        end
    end

    // Decoder enable code follows the state being entered so it is registered with it.
    always_comb begin
        case (state_s)
            ST_IDLE:  ena_s = 2'b01;
            ST_SHOW:  ena_s = 2'b10;
            ST_BLANK: ena_s = 2'b00;
            default:  ena_s = 2'b01;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            presc_r     <= {PW{1'b0}};
            blank_r     <= 8'd0;
            step_prev_r <= 1'b0;
            sel_r       <= 3'd0;
            ena_r       <= 2'b01;
            frame_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            presc_r     <= presc_s;
            blank_r     <= blank_s;
            step_prev_r <= bus.step;
            sel_r       <= sel_s;
            ena_r       <= ena_s;
            frame_r     <= frame_s;
        end
    end

    assign bus.sel   = sel_r;
    assign bus.ena   = ena_r;
    assign bus.frame = frame_r;
endmodule
